// File: rtl/useq.sv
// useq: microprogrammed control sequencer with a writable microcode store and an opcode dispatch map.
// Optional CALL/RET return register enabled by defining USEQ_CALL_EN.
module useq #(
  parameter int CTRL_W = 16,
  parameter int DEPTH  = 128,
  parameter int OPC_W  = 4,
  parameter int FLAG_W = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CSW   = $clog2(FLAG_W),
  localparam int MW    = 3 + CSW + AW + CTRL_W
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic              start,
  input  logic              stall,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [FLAG_W-1:0] flags,
  input  logic              wr_en,
  input  logic              wr_map,
  input  logic [AW-1:0]     wr_addr,
  input  logic [MW-1:0]     wr_data,
  output logic [CTRL_W-1:0] ctrl,
  output logic [AW-1:0]     upc,
  output logic              busy
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  localparam logic [2:0] SEQ_NEXT     = 3'd0;
  localparam logic [2:0] SEQ_JUMP     = 3'd1;
  localparam logic [2:0] SEQ_BRANCH   = 3'd2;
  localparam logic [2:0] SEQ_DISPATCH = 3'd3;
  localparam logic [2:0] SEQ_END      = 3'd4;
  localparam logic [2:0] SEQ_HALT     = 3'd5;
`ifdef USEQ_CALL_EN
  localparam logic [2:0] SEQ_CALL     = 3'd6;
  localparam logic [2:0] SEQ_RET      = 3'd7;
`endif

  state_e              state_q, state_d;
  logic [AW-1:0]       upc_q, upc_d, upc_inc_s;
  logic [MW-1:0]       store_q [DEPTH];
  logic [AW-1:0]       map_q [2**OPC_W];
  logic [MW-1:0]       word_s;
  logic [2:0]          seq_s;
  logic [CSW-1:0]      csel_s;
  logic [AW-1:0]       addr_s;
  logic                flag_s;
  logic                wr_ok_s;
`ifdef USEQ_CALL_EN
  logic [AW-1:0]       ret_q, ret_d;
`endif

  // Zero-latency fetch: the word at the current micro-PC is decoded combinationally.
  assign word_s    = store_q[upc_q];
  assign seq_s     = word_s[MW-1 -: 3];
  assign csel_s    = word_s[CTRL_W+AW +: CSW];
  assign addr_s    = word_s[CTRL_W +: AW];
  assign upc_inc_s = upc_q + AW'(1'b1);
  assign wr_ok_s   = n_reset && wr_en && (state_q == S_IDLE);

  // Condition select; out-of-range selectors fall back to flag 0.
  always_comb begin
    flag_s = flags[0];
    if (int'(csel_s) < FLAG_W) begin
      flag_s = flags[csel_s];
    end else begin
      flag_s = flags[0];
    end
  end

  // Load port into microcode store and dispatch map (contents are not reset).
  always_ff @(posedge clock) begin
    if (wr_ok_s && !wr_map) begin
      store_q[wr_addr] <= wr_data;
    end
    if (wr_ok_s && wr_map) begin
      map_q[OPC_W'(wr_addr)] <= wr_data[AW-1:0];
    end
  end

  // Sequencer state and micro-PC registers.
  always_ff @(posedge clock) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
      upc_q   <= {AW{1'b0}};
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
    end
  end

`ifdef USEQ_CALL_EN
  // Single-level return address register.
  always_ff @(posedge clock) begin
    if (!n_reset) begin
      ret_q <= {AW{1'b0}};
    end else begin
      ret_q <= ret_d;
    end
  end
`endif

  // Next-state and micro-PC sequencing.
  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
`ifdef USEQ_CALL_EN
    ret_d   = ret_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          upc_d   = {AW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (stall) begin
          state_d = S_RUN;
        end else begin
          case (seq_s)
            SEQ_NEXT:     upc_d = upc_inc_s;
            SEQ_JUMP:     upc_d = addr_s;
            SEQ_BRANCH:   upc_d = flag_s ? addr_s : upc_inc_s;
            SEQ_DISPATCH: upc_d = map_q[opcode];
            SEQ_END:      upc_d = {AW{1'b0}};
            SEQ_HALT: begin
              state_d = S_IDLE;
              upc_d   = {AW{1'b0}};
            end
`ifdef USEQ_CALL_EN
            SEQ_CALL: begin
              ret_d = upc_inc_s;
              upc_d = addr_s;
            end
            SEQ_RET:      upc_d = ret_q;
`endif
            default:      upc_d = upc_inc_s;
          endcase
        end
      end
      default: begin
        state_d = S_IDLE;
        upc_d   = {AW{1'b0}};
      end
    endcase
  end

  assign ctrl = (state_q == S_RUN) ? word_s[CTRL_W-1:0] : {CTRL_W{1'b0}};
  assign upc  = upc_q;
  assign busy = (state_q == S_RUN);

endmodule
